// File: rtl/mkg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mkg_pkg
// Brief   : MKG reversible-gate lane map and word rotation shared by the
//           cascade pipeline.
// Rev     : 1.0
// ============================================================================
package mkg_pkg;

    localparam int LANE_W     = 4;
    localparam int ROTL_MAX_W = 1024;
    localparam int ROTL_IDX_W = 10;

    // 4-in/4-out MKG gate, lane bits {A,B,C,D} -> {P,Q,R,S}
    function automatic logic [LANE_W-1:0] mkg4(input logic [LANE_W-1:0] x);
        logic a;
        logic b;
        logic c;
        logic d;
        logic t;
        a = x[3];
        b = x[2];
        c = x[1];
        d = x[0];
        t = (~a & ~d) ^ ~b;
        return {a, c, t ^ c, (t & c) ^ ((a & b) ^ d)};
    endfunction

    // Circular left rotate of the low w bits of x by r; bits above w stay zero.
    function automatic logic [ROTL_MAX_W-1:0] rotl(
        input logic [ROTL_MAX_W-1:0] x,
        input int                    w,
        input int                    r
    );
        logic [ROTL_MAX_W-1:0] y;
        logic [ROTL_IDX_W-1:0] dst;
        y = '0;
        for (int i = 0; i < w; i++) begin
            dst    = ROTL_IDX_W'((i + r) % w);
            y[dst] = x[ROTL_IDX_W'(i)];
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mkg_layer.sv
`default_nettype none
// ============================================================================
// Module  : mkg_layer
// Brief   : One combinational cascade layer: WIDTH/4 parallel MKG gates
//           followed by a left rotate so the next layer straddles lanes.
// Rev     : 1.0
// ============================================================================
module mkg_layer
    import mkg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ROT   = 2
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_gated;

    for (genvar i = 0; i < WIDTH / LANE_W; i++) begin : g_lane
        assign w_gated[LANE_W*i +: LANE_W] = mkg4(i_data[LANE_W*i +: LANE_W]);
    end

    assign o_data = WIDTH'(rotl(ROTL_MAX_W'(w_gated), WIDTH, ROT));

endmodule
`default_nettype wire

// File: rtl/mkg_cascade_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mkg_cascade_pipe
// Brief   : STAGES-deep registered cascade of MKG gate layers with global
//           valid/ready stall and an output handshake counter.
// Rev     : 1.0
// ============================================================================
module mkg_cascade_pipe
    import mkg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int ROT    = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    if ((WIDTH % LANE_W) != 0 || WIDTH < LANE_W || WIDTH > ROTL_MAX_W ||
        STAGES < 1 || ROT < 0 || ROT >= WIDTH || CNT_W < 1) begin : g_param_check
        $fatal(1, "mkg_cascade_pipe: illegal WIDTH/STAGES/ROT/CNT_W combination");
    end

    logic [STAGES-1:0] r_valid_q;
    logic [STAGES-1:0] w_valid_d;
    logic [WIDTH-1:0]  r_data_q    [STAGES];
    logic [WIDTH-1:0]  w_data_d    [STAGES];
    logic [WIDTH-1:0]  w_layer_out [STAGES];
    logic [CNT_W-1:0]  r_count_q;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_adv;
    logic              w_out_fire;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            mkg_layer #(.WIDTH(WIDTH), .ROT(ROT)) u_layer (
                .i_data (in_data),
                .o_data (w_layer_out[k])
            );
        end else begin : g_tail
            mkg_layer #(.WIDTH(WIDTH), .ROT(ROT)) u_layer (
                .i_data (r_data_q[k-1]),
                .o_data (w_layer_out[k])
            );
        end
    end

    // Stall is global: a bubble in flight does not absorb backpressure.
    assign w_adv      = ~r_valid_q[STAGES-1] | out_ready;
    assign w_out_fire = r_valid_q[STAGES-1] & out_ready;

    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        w_count_d = r_count_q + CNT_W'(w_out_fire);
        if (w_adv) begin
            w_valid_d[0] = in_valid;
            w_data_d[0]  = w_layer_out[0];
            for (int k = 1; k < STAGES; k++) begin
                w_valid_d[k] = r_valid_q[k-1];
                w_data_d[k]  = w_layer_out[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= '0;
            r_count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data_q[k] <= '0;
            end
        end else begin
            r_valid_q <= w_valid_d;
            r_count_q <= w_count_d;
            for (int k = 0; k < STAGES; k++) begin
                r_data_q[k] <= w_data_d[k];
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_valid_q[STAGES-1];
    assign out_data  = r_data_q[STAGES-1];
    assign out_count = r_count_q;

endmodule
`default_nettype wire

// File: doc/mkg_cascade_pipe.md
Name: mkg_cascade_pipe

Overview:
- Pipelined, parametrised cascade of 4-in/4-out MKG reversible gates for the APUF datapath.
- Each layer applies WIDTH/4 MKG gates in parallel across a WIDTH-bit word, then rotates the word so the next layer's gates straddle previous lanes.
- STAGES layers, each followed by a register, with valid/ready flow control and a processed-word counter.
- Sits between challenge generation and the arbiter chain, as a reversible challenge-mixing network.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 4 and at least 4.
- STAGES, 4, number of gate layers, which equals the pipeline depth; at least 1.
- ROT, 2, left-rotate amount in bits applied after each layer; 0 ≤ ROT < WIDTH.
- CNT_W, 16, width of the output word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  challenge word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  WIDTH  mixed word.
- out_count  output  CNT_W  number of output handshakes completed, modulo 2^CNT_W.

Behaviour:
- One clock; reset is asynchronous and active-low: clk and rst_n.
- MKG gate, lane i, bits [4i+3:4i] = {A,B,C,D}:
  - P=A, Q=C.
  - R=((~A&~D)^~B)^C.
  - S=(((~A&~D)^~B)&C)^((A&B)^D).
  - Output lane = {P,Q,R,S}.
- Layer function L(x) = rotl(gates(x), ROT), where rotl is a circular left rotate over WIDTH bits. ROT=0 means no rotation.
- Stage k register (k=0..STAGES-1) holds data_k and valid_k. Stage 0 loads L(in_data); stage k loads L(data_{k-1}).
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational.
  - On adv: valid_0 <= in_valid & in_ready; valid_k <= valid_{k-1}; data registers shift.
  - On ~adv: all stage registers hold.
- Data registers may load when their incoming valid is 0; their contents are don't-care while invalid.
- out_valid = valid_{STAGES-1}; out_data = data_{STAGES-1}.
- Latency STAGES cycles from input handshake to out_valid, with no stall.
- Throughput 1 word/cycle while out_ready=1.
- Bubbles propagate; the pipeline is not compacted. Stall is global: a bubble in flight does not absorb backpressure.
- out_count increments on out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output handshake in the same cycle is allowed; both complete.
- Reset values: all valid_k=0, data_k=0, out_count=0, hence out_valid=0 and out_data=0.
- in_ready is 1 during reset deassertion (adv=1 because out_valid=0).
- Reset asserted mid-operation discards all in-flight words immediately (async) and does not count them.
- out_data is stable while out_valid & ~out_ready (AXI-style hold).
- in_data is sampled only on in_valid & in_ready; in_valid does not need to be held when in_ready=0. Upstream retries.
- Elaboration check: WIDTH%4 != 0, STAGES < 1, or ROT ≥ WIDTH produces a fatal elaboration error.

Decomposition:
- Package mkg_pkg: function mkg4 (4-bit lane map), function rotl parametrised by width, and the lane width constant LANE_W=4.
- Sub-module mkg_layer (params WIDTH, ROT): purely combinational; generates WIDTH/4 mkg4 instances plus the rotation.
- mkg_cascade_pipe: generates STAGES mkg_layer instances, owns the valid/data registers, the adv logic and the counter.

Test Plan:
1. Single-lane truth table: WIDTH=4, STAGES=1, ROT=0; inputs 0x0, 0xF, 0x1, 0x2 give outputs 0x0, 0xE, 0x3, 0x6 one cycle after each accept. Sweep all 16 inputs: outputs are a permutation (all distinct).
2. Latency/throughput with defaults: stream 8 words back-to-back, out_ready=1. The first out_valid appears 4 cycles after the first accept, the rest arrive on consecutive cycles, each matching the reference model rotl(gates(.),2)^4. Final out_count=8.
3. Backpressure: with defaults, drop out_ready for 3 cycles while the pipeline is full.
   - in_ready=0 throughout.
   - out_data is held unchanged.
   - No word is lost or duplicated.
   - Order is preserved after release.
4. Bubbles: toggle in_valid 1,0,1,0 with out_ready=1. The out_valid pattern reproduces 1,0,1,0 shifted by 4 cycles.
5. Reset mid-stream: assert rst_n=0 asynchronously with 3 words in flight.
   - out_valid, out_data and out_count go to 0 immediately, without waiting for a clock edge.
   - After release, the next word emerges after exactly 4 cycles.
6. Counter wrap: CNT_W=4; complete 17 output handshakes; out_count reads 1.
